// File: rtl/jk_pkg.sv
// Shared J/K input encodings for the modulo counter and its flip-flop cells.
package jk_pkg;

  typedef logic [1:0] jk_t;  // {J, K}

  localparam jk_t JK_HOLD   = 2'b00;
  localparam jk_t JK_RESET  = 2'b01;
  localparam jk_t JK_SET    = 2'b10;
  localparam jk_t JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_cell_ar.sv
// Single JK flip-flop with asynchronous active-high reset to q=0, qbar=1.
module jk_cell_ar
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  jk_t  jk,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case (jk)
        JK_HOLD:  q <= q;
        JK_RESET: q <= 1'b0;
        JK_SET:   q <= 1'b1;
        default:  q <= ~q;
      endcase
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter: computes per-bit J/K drive for a bank of JK cells
// that hold the count, plus terminal-count, wrap and rejected-load flags.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable for the range check.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_bar;
  logic [WIDTH-1:0] next_cnt;
  logic             at_max;
  logic             at_zero;
  logic             load_ok;
  logic             load_bad;
  jk_t              jk [WIDTH];

  assign at_max   = (Q == MAX_VAL);
  assign at_zero  = &q_bar;
  assign tc       = up ? at_max : at_zero;
  assign load_ok  = load && ({1'b0, load_val} < MOD_EXT);
  assign load_bad = load && !load_ok;

  always_comb begin
    next_cnt = Q;
    if (up) begin
      next_cnt = at_max ? '0 : Q + WIDTH'(1);
    end else begin
      next_cnt = at_zero ? MAX_VAL : Q - WIDTH'(1);
    end
  end

  // Loads drive set/reset directly; counting only toggles the bits that change.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      jk[i] = JK_HOLD;
      if (load_ok) begin
        jk[i] = load_val[i] ? JK_SET : JK_RESET;
      end else if (!load && en && (next_cnt[i] ^ Q[i])) begin
        jk[i] = JK_TOGGLE;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell_ar u_cell (
      .clk  (CLK),
      .rst  (rst),
      .jk   (jk[i]),
      .q    (Q[i]),
      .qbar (q_bar[i])
    );
  end

  // A counting edge taken while tc is high is exactly a wrap edge.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= !load && en && tc;
      load_err <= load_bad;
    end
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter built from a bank of JK flip-flop cells.
- This block is the stage directly upstream of the JK cells: it computes the J/K input pair for every bit each cycle, and the cells hold the count state.
- Used as a cycle/event counter and a clock-enable generator; the terminal-count and wrap outputs feed downstream control logic.

Parameters:
- WIDTH, 4, number of count bits / JK cells; must satisfy 2**WIDTH >= MODULUS.
- MODULUS, 10, count range is 0..MODULUS-1; legal range 2..2**WIDTH.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; when high and no load, advance one step per cycle.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled every cycle.
- load  input  1  synchronous parallel load request.
- load_val  input  WIDTH  value to load.
- Q  output  WIDTH  current count, straight from the JK cell outputs.
- tc  output  1  combinational terminal count: (up && Q==MODULUS-1) || (!up && Q==0); independent of en.
- wrap  output  1  registered one-cycle pulse, high the cycle after the count wrapped.
- load_err  output  1  registered one-cycle pulse, high the cycle after a rejected load.

Behaviour:
- Reset (rst high, asynchronous): Q=0, wrap=0, load_err=0 immediately, without waiting for CLK. Release is synchronous to the next CLK edge; the first update happens on the first edge with rst low.
- Priority per edge: rst > load > en > hold.
- Load, in range (load=1, load_val < MODULUS):
  - Q <= load_val next edge.
  - Per cell J=load_val[i], K=~load_val[i].
  - wrap=0, load_err=0.
- Load, out of range (load=1, load_val >= MODULUS):
  - Q holds, and en is ignored that cycle.
  - load_err=1 for exactly one cycle after the edge.
- Count (load=0, en=1):
  - up=1: Q <= (Q==MODULUS-1) ? 0 : Q+1.
  - up=0: Q <= (Q==0) ? MODULUS-1 : Q-1.
  - Implemented as toggle-only: per cell J=K=(next[i]^Q[i]).
  - wrap=1 the cycle after a wrap edge (MODULUS-1->0 up, or 0->MODULUS-1 down); otherwise wrap=0.
- Hold (load=0, en=0): J=K=0 for all cells; Q unchanged; wrap=0, load_err=0.
- Latency: Q reflects load or count one cycle after the request edge. tc is same-cycle combinational from Q and up.
- Direction change mid-count: takes effect on the very next enabled edge; no pipeline or skid.
- Reset asserted mid-count or mid-load overrides everything; no pending state survives.
- Arithmetic is WIDTH bits with no carry out; values >= MODULUS must never appear on Q except through X-state before reset.
- MODULUS = 2**WIDTH: the wrap comparisons still apply and the natural binary rollover must match them.

Decomposition:
- Shared package jk_pkg holds:
  - constant JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11;
  - typedef jk_t (2-bit {J,K} pair).
- One sub-module, jk_cell_ar: a single JK flip-flop with asynchronous active-high reset to Q=0, Qbar=1, instantiated WIDTH times via generate.
- Next-state and J/K encode logic stays in jk_mod_counter.

Test Plan:
- Reset mid-count: WIDTH=4, MODULUS=10, count to Q=6, assert rst between clock edges -> Q=0 immediately, wrap=0; after release with en=1,up=1, Q=1 one edge later.
- Up wrap: en=1, up=1 from Q=0 for 12 edges -> Q goes 1..9,0,1,2. tc=1 while Q=9. wrap=1 only in the cycle where Q first reads 0 after 9.
- Down wrap: load 2, then en=1, up=0 -> Q sequence 2,1,0,9,8. tc=1 at Q=0. wrap pulses once, when Q reads 9.
- Load vs count: load=1, load_val=7, en=1, up=1 same cycle -> Q=7 next edge (not 8). load=1, load_val=12 -> Q holds, load_err=1 for one cycle, wrap=0.
- Hold and direction flip: en=0 for 5 edges at Q=4 -> Q stays 4. Then en=1 with up toggling every cycle starting up=1 -> Q sequence 5,4,5,4.
- Full binary modulus: WIDTH=3, MODULUS=8, up from 0 -> Q rolls 7->0 with wrap=1 one cycle. Down from 0 -> Q=7, wrap=1.
